// File: rtl/uart_arb_pkg.sv
// Shared constants and FSM state encoding for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the search starts just after last_id_i
// and the first requester found in that order wins.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_id_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  winner_o
);

  // Walk from the farthest candidate to the nearest so that the nearest set bit wins.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      valid_o  = valid_o | req_i[(int'(last_id_i) + k) % N_REQ];
      winner_o = req_i[(int'(last_id_i) + k) % N_REQ] ?
                 ID_W'((int'(last_id_i) + k) % N_REQ) : winner_o;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ requesters,
// with a watchdog that abandons a frame when tx_done never arrives.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      CP,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      tx_en,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  cur_id,
  output logic                      timeout_err
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              tx_en_q, tx_en_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              pick_valid_s;
  logic [ID_W-1:0]   pick_id_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req_i     (req),
    .last_id_i (last_id_q),
    .valid_o   (pick_valid_s),
    .winner_o  (pick_id_s)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    cur_id_d  = cur_id_q;
    tx_data_d = tx_data_q;
    grant_d   = '0;
    tx_en_d   = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;
    wd_d      = wd_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d            = ISSUE;
          last_id_d          = pick_id_s;
          cur_id_d           = pick_id_s;
          tx_data_d          = req_data[int'(pick_id_s)*DATA_W +: DATA_W];
          grant_d[pick_id_s] = 1'b1;
          tx_en_d            = 1'b1;
          busy_d             = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: begin
        // A tx_done coinciding with expiry counts as a normal completion.
        if (tx_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 first in line.
  always_ff @(posedge CP or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      last_id_q <= ID_W'(N_REQ - 1);
      cur_id_q  <= '0;
      tx_data_q <= '0;
      grant_q   <= '0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      cur_id_q  <= cur_id_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      tx_en_q   <= tx_en_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
    end
  end

  assign grant       = grant_q;
  assign tx_en       = tx_en_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign cur_id      = cur_id_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8, TIMEOUT=16).
module tb_uart_tx_arbiter;

  logic        CP;
  logic        RST;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  cur_id;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(
    .N_REQ   (4),
    .DATA_W  (8),
    .TIMEOUT (16)
  ) dut (
    .CP          (CP),
    .RST         (RST),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .cur_id      (cur_id),
    .timeout_err (timeout_err)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_tx_en"}, 32'(tx_en), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cur_id"}, 32'(cur_id), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // Arbiter must be in IDLE with req set; tx_done is sampled dd edges after the decision edge.
  task automatic do_xfer(input string tag, input logic [3:0] eg, input logic [7:0] ed,
                         input logic [1:0] eid, input int dd);
    tick();
    chk({tag, "_grant"}, 32'(grant), 32'(eg));
    chk({tag, "_tx_en"}, 32'(tx_en), 32'd1);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'(ed));
    chk({tag, "_cur_id"}, 32'(cur_id), 32'(eid));
    chk({tag, "_busy_issue"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_grant_pulse"}, 32'(grant), 32'd0);
    chk({tag, "_tx_en_pulse"}, 32'(tx_en), 32'd0);
    chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
    repeat (dd - 2) tick();
    chk({tag, "_busy_before_done"}, 32'(busy), 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
    chk({tag, "_tx_en_idle"}, 32'(tx_en), 32'd0);
    chk({tag, "_tx_data_held"}, 32'(tx_data), 32'(ed));
  endtask

  initial begin
    RST      = 1'b0;
    req      = 4'b0000;
    req_data = 32'd0;
    tx_done  = 1'b0;
    #12;
    chk_all_zero("reset");
    tick();
    RST = 1'b1;
    tick();
    chk_all_zero("post_reset_idle");

    // Fairness: all four held, tx_done five cycles after each tx_en.
    req_data = {8'd40, 8'd30, 8'd20, 8'd10};
    req      = 4'b1111;
    do_xfer("rr0", 4'b0001, 8'd10, 2'd0, 5);
    do_xfer("rr1", 4'b0010, 8'd20, 2'd1, 5);
    do_xfer("rr2", 4'b0100, 8'd30, 2'd2, 5);
    do_xfer("rr3", 4'b1000, 8'd40, 2'd3, 5);
    do_xfer("rr4", 4'b0001, 8'd10, 2'd0, 5);
    req = 4'b0000;

    // Single requester, byte 42, tx_done ten cycles after tx_en.
    req_data = {8'd0, 8'd0, 8'd0, 8'd42};
    req      = 4'b0001;
    do_xfer("single", 4'b0001, 8'd42, 2'd0, 10);
    req = 4'b0000;

    // Contention with last_id=0: requester 2 first, then 0.
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req      = 4'b0101;
    do_xfer("cont_a", 4'b0100, 8'h33, 2'd2, 3);
    do_xfer("cont_b", 4'b0001, 8'h11, 2'd0, 3);
    req = 4'b0000;

    // Stray tx_done in IDLE and in ISSUE must not end the transfer.
    tx_done = 1'b1;
    tick();
    chk("stray_idle_busy", 32'(busy), 32'd0);
    chk("stray_idle_tx_en", 32'(tx_en), 32'd0);
    req = 4'b1000;
    tick();
    chk("stray_grant", 32'(grant), 32'b1000);
    chk("stray_tx_en", 32'(tx_en), 32'd1);
    chk("stray_tx_data", 32'(tx_data), 32'h44);
    req = 4'b0000;
    tick();
    tx_done = 1'b0;
    chk("stray_issue_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("stray_still_wait", 32'(busy), 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("stray_done_busy", 32'(busy), 32'd0);

    // tx_done on the very cycle the watchdog expires counts as done.
    req = 4'b0001;
    do_xfer("edge_done", 4'b0001, 8'h11, 2'd0, 17);
    req = 4'b0000;
    chk("edge_done_no_err", 32'(timeout_err), 32'd0);

    // Timeout: requester 1, tx_done never arrives.
    req = 4'b0010;
    tick();
    chk("to_grant", 32'(grant), 32'b0010);
    chk("to_tx_data", 32'(tx_data), 32'h22);
    req = 4'b0000;
    tick();
    repeat (15) tick();
    chk("to_busy_16th_wait", 32'(busy), 32'd1);
    chk("to_err_before", 32'(timeout_err), 32'd0);
    tick();
    chk("to_busy_after", 32'(busy), 32'd0);
    chk("to_err_set", 32'(timeout_err), 32'd1);
    req = 4'b0100;
    do_xfer("after_to", 4'b0100, 8'h33, 2'd2, 3);
    req = 4'b0000;
    chk("err_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT clears everything at once; requester 3 then wins alone.
    req = 4'b0001;
    tick();
    chk("rst_pre_grant", 32'(grant), 32'b0001);
    req = 4'b0000;
    tick();
    #2;
    RST = 1'b0;
    #1;
    chk_all_zero("rst_mid_wait");
    req = 4'b1000;
    repeat (3) @(posedge CP);
    #1;
    chk_all_zero("rst_held");
    RST = 1'b1;
    #2;
    chk("rst_release_tx_en", 32'(tx_en), 32'd0);
    chk("rst_release_grant", 32'(grant), 32'd0);
    do_xfer("post_rst", 4'b1000, 8'h44, 2'd3, 3);
    req = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
